// File: rtl/mnist_image_sender.sv
// mnist_image_sender: streams one image from a synchronous memory to a UART
// transmitter at the line rate, then waits for a one-byte classification reply.
module mnist_image_sender #(
    parameter int unsigned PIXELS         = 784,
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned BYTE_GAP       = 4774,
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        pi_data,
    output logic              pi_flag,
    input  logic [7:0]        po_data,
    input  logic              po_flag,
    output logic              busy,
    output logic              done,
    output logic [7:0]        result,
    output logic              timed_out
);

    // READ, LATCH and SEND take three of the BYTE_GAP cycles between strobes;
    // GAP fills the remaining BYTE_GAP-3 cycles.
    localparam int unsigned GapCount = BYTE_GAP - 3;
    localparam int unsigned GapW     = (GapCount > 1) ? $clog2(GapCount) : 1;
    localparam int unsigned WaitW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned IdxW     = (PIXELS > 1) ? $clog2(PIXELS) : 1;

    localparam logic [GapW-1:0]  GapLast  = GapW'(GapCount - 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT_CYCLES - 1);
    localparam logic [IdxW-1:0]  IdxLast  = IdxW'(PIXELS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StLatch,
        StSend,
        StGap,
        StWaitRes,
        StFinish
    } state_e;

    state_e           state_q, state_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [GapW-1:0]  gap_q, gap_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [7:0]       pi_data_q, pi_data_d;
    logic [7:0]       result_q, result_d;
    logic             timed_out_q, timed_out_d;

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            gap_q       <= '0;
            wait_q      <= '0;
            pi_data_q   <= '0;
            result_q    <= '0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            wait_q      <= wait_d;
            pi_data_q   <= pi_data_d;
            result_q    <= result_d;
            timed_out_q <= timed_out_d;
        end
    end

    // Next-state logic and state-decoded strobes.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        gap_d       = gap_q;
        wait_d      = wait_q;
        pi_data_d   = pi_data_q;
        result_d    = result_q;
        timed_out_d = timed_out_q;
        mem_rd_en   = 1'b0;
        pi_flag     = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StRead;
                    idx_d       = '0;
                    result_d    = '0;
                    timed_out_d = 1'b0;
                end
            end
            StRead: begin
                busy      = 1'b1;
                mem_rd_en = 1'b1;
                state_d   = StLatch;
            end
            StLatch: begin
                busy      = 1'b1;
                pi_data_d = mem_rdata;
                state_d   = StSend;
            end
            StSend: begin
                busy    = 1'b1;
                pi_flag = 1'b1;
                gap_d   = '0;
                wait_d  = '0;
                // The final byte skips GAP; the reply window starts next cycle.
                if (idx_q == IdxLast) begin
                    state_d = StWaitRes;
                end else begin
                    state_d = StGap;
                end
            end
            StGap: begin
                busy = 1'b1;
                if (gap_q == GapLast) begin
                    idx_d   = idx_q + IdxW'(1);
                    state_d = StRead;
                end else begin
                    gap_d = gap_q + GapW'(1);
                end
            end
            StWaitRes: begin
                busy = 1'b1;
                // A reply on the last window cycle still beats the timeout.
                if (po_flag) begin
                    result_d = po_data;
                    state_d  = StFinish;
                end else if (wait_q == WaitLast) begin
                    timed_out_d = 1'b1;
                    state_d     = StFinish;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StFinish: begin
                done = 1'b1;
                // A start in the done cycle begins the next transfer at once.
                if (start) begin
                    state_d     = StRead;
                    idx_d       = '0;
                    result_d    = '0;
                    timed_out_d = 1'b0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign mem_addr  = ADDR_W'(idx_q);
    assign pi_data   = pi_data_q;
    assign result    = result_q;
    assign timed_out = timed_out_q;

endmodule

// File: tb/tb_mnist_image_sender.sv
// tb_mnist_image_sender: random and directed stimulus against a cycle-offset
// model of the image sender, with literal checks on the directed scenarios.
module tb_mnist_image_sender;

    localparam int P  = 4;
    localparam int AW = 2;
    localparam int G  = 8;
    localparam int TO = 50;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata = 8'h00;
    logic [7:0]    pi_data;
    logic          pi_flag;
    logic [7:0]    po_data;
    logic          po_flag;
    logic          busy;
    logic          done;
    logic [7:0]    result;
    logic          timed_out;

    mnist_image_sender #(
        .PIXELS(P),
        .ADDR_W(AW),
        .BYTE_GAP(G),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .sys_clk(clk),
        .sys_rst(rst),
        .start(start),
        .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr),
        .mem_rdata(mem_rdata),
        .pi_data(pi_data),
        .pi_flag(pi_flag),
        .po_data(po_data),
        .po_flag(po_flag),
        .busy(busy),
        .done(done),
        .result(result),
        .timed_out(timed_out)
    );

    always #5 clk = ~clk;

    // Synchronous image memory: data one cycle after the read enable.
    logic [7:0] mem [P];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model state: a transfer is described by its start cycle and, once known,
    // the cycle on which it completes.
    bit         m_active = 1'b0;
    int         m_t0 = 0;
    int         m_done_at = -1;
    logic [7:0] m_pi = 8'h00;
    logic [7:0] m_result = 8'h00;
    logic       m_to = 1'b0;

    // Recording of DUT events relative to a scenario's first cycle.
    int         base = 0;
    int         done_off = -1;
    int         s_off[$];
    logic [7:0] s_dat[$];

    always @(negedge clk) begin : cmp
        logic          e_rd, e_flag, e_busy, e_done;
        logic [AW-1:0] e_addr;
        int            off, t_last;
        e_rd   = 1'b0;
        e_flag = 1'b0;
        e_busy = 1'b0;
        e_done = 1'b0;
        e_addr = '0;
        if (rst) begin
            m_active  = 1'b0;
            m_done_at = -1;
            m_pi      = 8'h00;
            m_result  = 8'h00;
            m_to      = 1'b0;
        end else if (m_active) begin
            off    = cyc - m_t0;
            e_done = (cyc == m_done_at);
            e_busy = (off >= 1) && !e_done;
            if (off >= 1 && (off - 1) % G == 0 && (off - 1) / G < P) begin
                e_rd   = 1'b1;
                e_addr = AW'((off - 1) / G);
            end
            if (off >= 3 && (off - 3) % G == 0 && (off - 3) / G < P) begin
                e_flag = 1'b1;
                m_pi   = mem[(off - 3) / G];
            end
        end

        check("busy", 32'(busy), 32'(e_busy));
        check("done", 32'(done), 32'(e_done));
        check("mem_rd_en", 32'(mem_rd_en), 32'(e_rd));
        if (e_rd) check("mem_addr", 32'(mem_addr), 32'(e_addr));
        check("pi_flag", 32'(pi_flag), 32'(e_flag));
        check("pi_data", 32'(pi_data), 32'(m_pi));
        check("result", 32'(result), 32'(m_result));
        check("timed_out", 32'(timed_out), 32'(m_to));

        if (pi_flag === 1'b1) begin
            s_off.push_back(cyc - base);
            s_dat.push_back(pi_data);
        end
        if (done === 1'b1 && done_off < 0) done_off = cyc - base;

        if (!rst) begin
            if (m_active && m_done_at < 0) begin
                t_last = m_t0 + 3 + (P - 1) * G;
                if (cyc >= t_last + 1 && cyc <= t_last + TO) begin
                    if (po_flag) begin
                        m_result  = po_data;
                        m_done_at = cyc + 1;
                    end else if (cyc == t_last + TO) begin
                        m_to      = 1'b1;
                        m_done_at = cyc + 1;
                    end
                end
            end
            if (m_active && cyc == m_done_at) m_active = 1'b0;
            if (!m_active && start) begin
                m_active  = 1'b1;
                m_t0      = cyc;
                m_done_at = -1;
                m_result  = 8'h00;
                m_to      = 1'b0;
            end
        end
    end

    task automatic tick(input logic s, input logic pf, input logic [7:0] pd, input logic r);
        @(posedge clk);
        #1;
        start   = s;
        po_flag = pf;
        po_data = pd;
        rst     = r;
    endtask

    task automatic mark();
        base     = cyc;
        done_off = -1;
        s_off.delete();
        s_dat.delete();
    endtask

    // One transfer started on the first cycle, optional reply at offset reply_at.
    task automatic xfer(input int reply_at, input logic [7:0] rd, input int len);
        for (int i = 0; i < len; i++) begin
            tick(i == 0, i == reply_at, (i == reply_at) ? rd : 8'($urandom), 1'b0);
            if (i == 0) mark();
        end
        tick(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        po_flag = 1'b0;
        po_data = 8'h00;
        mem[0]  = 8'h11;
        mem[1]  = 8'h22;
        mem[2]  = 8'h33;
        mem[3]  = 8'h44;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 8'h00, 1'b1);
        tick(1'b0, 1'b0, 8'h00, 1'b0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_result", 32'(result), 32'd0);

        // Basic transfer with reply at offset 40.
        xfer(40, 8'h07, 45);
        check("s1_count", 32'(s_off.size()), 32'd4);
        if (s_off.size() == 4) begin
            check("s1_off0", 32'(s_off[0]), 32'd3);
            check("s1_off1", 32'(s_off[1]), 32'd11);
            check("s1_off2", 32'(s_off[2]), 32'd19);
            check("s1_off3", 32'(s_off[3]), 32'd27);
            check("s1_dat0", 32'(s_dat[0]), 32'h11);
            check("s1_dat3", 32'(s_dat[3]), 32'h44);
        end
        check("s1_done", 32'(done_off), 32'd41);
        check("s1_result", 32'(result), 32'h07);
        check("s1_to", 32'(timed_out), 32'd0);

        // No reply: timeout.
        xfer(-1, 8'h00, 82);
        check("s2_done", 32'(done_off), 32'd78);
        check("s2_to", 32'(timed_out), 32'd1);
        check("s2_result", 32'(result), 32'd0);

        // Reply on the last window cycle.
        xfer(77, 8'h5A, 82);
        check("s3_done", 32'(done_off), 32'd78);
        check("s3_result", 32'(result), 32'h5A);
        check("s3_to", 32'(timed_out), 32'd0);

        // Stale reply, ignored starts, only the first reply captured.
        for (int i = 0; i < 45; i++) begin
            tick(i == 0 || i == 5 || i == 20,
                 i == 15 || i == 35 || i == 36,
                 (i == 15) ? 8'h09 : (i == 35) ? 8'h05 : (i == 36) ? 8'h06 : 8'h00,
                 1'b0);
            if (i == 0) mark();
        end
        tick(1'b0, 1'b0, 8'h00, 1'b0);
        check("s4_result", 32'(result), 32'h05);
        check("s4_count", 32'(s_off.size()), 32'd4);
        check("s4_done", 32'(done_off), 32'd36);

        // Reset mid-transfer, then a clean restart.
        for (int i = 0; i < 20; i++) begin
            tick(i == 0, 1'b0, 8'h00, i == 14 || i == 15);
            if (i == 0) mark();
        end
        check("s5_count", 32'(s_off.size()), 32'd2);
        check("s5_nodone", 32'(done_off), 32'hFFFF_FFFF);
        idle(5);
        xfer(30, 8'h3C, 35);
        check("s5_restart_off", 32'(s_off.size() > 0 ? s_off[0] : -1), 32'd3);
        check("s5_restart_dat", 32'(s_dat.size() > 0 ? s_dat[0] : 8'h00), 32'h11);
        check("s5_result", 32'(result), 32'h3C);

        // Start held high: back-to-back transfers.
        for (int i = 0; i < 100; i++) begin
            tick(1'b1, i == 40 || i == 90, (i == 40) ? 8'hA1 : 8'hA2, 1'b0);
            if (i == 0) mark();
        end
        tick(1'b0, 1'b0, 8'h00, 1'b0);
        check("s6_done", 32'(done_off), 32'd41);
        check("s6_second", 32'(s_off.size() > 4 ? s_off[4] : -1), 32'd44);
        check("s6_count", 32'(s_off.size()), 32'd9);
        idle(100);

        // Random traffic with random image contents.
        for (int it = 0; it < 25; it++) begin
            for (int k = 0; k < P; k++) mem[k] = 8'($urandom);
            for (int i = 0; i < 120; i++) begin
                tick($urandom_range(0, 19) == 0, $urandom_range(0, 11) == 0,
                     8'($urandom), $urandom_range(0, 199) == 0);
            end
            idle(100);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mnist_image_sender.md
Name: mnist_image_sender

Overview:
- Host-side initiator for the MNIST pixel-stream UART protocol: reads one image of PIXELS bytes from a synchronous image memory.
- Issues the bytes one at a time as single-cycle strobes to a uart_tx instance, paced to the line rate.
- After the last byte, waits for the one-byte classification reply from a uart_rx instance; reports the result or a timeout.
- Used for loopback/self-test boards and as the bench driver for the inference system.

Parameters:
- PIXELS, 784, bytes per image frame.
- ADDR_W, 10, image-memory address width; must satisfy 2^ADDR_W >= PIXELS.
- BYTE_GAP, 4774, clock cycles between successive pi_flag strobes (50 MHz / 115200 x 11 bits); must be >= 4.
- TIMEOUT_CYCLES, 5_000_000, reply window in cycles after the final pi_flag.

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  asynchronous, active-high reset
- start  in  1  request one image transfer; sampled only when busy=0
- mem_rd_en  out  1  image-memory read enable
- mem_addr  out  ADDR_W  image-memory address
- mem_rdata  in  8  read data, valid exactly 1 cycle after mem_rd_en
- pi_data  out  8  byte to uart_tx
- pi_flag  out  1  one-cycle send strobe to uart_tx
- po_data  in  8  byte from uart_rx
- po_flag  in  1  one-cycle receive strobe from uart_rx
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- result  out  8  captured reply byte
- timed_out  out  1  last transfer ended without a reply

Behaviour:
- Reset (async, any time, including mid-transfer):
  - All outputs 0; FSM to IDLE; counters cleared.
  - No pi_flag is issued in or after the reset cycle.
- FSM states: IDLE, READ, LATCH, SEND, GAP, WAIT_RES, FINISH.
- IDLE:
  - start=1 moves to READ.
  - On entry to READ: pixel index=0, result=0, timed_out=0.
- Byte cycle (index i):
  - READ: mem_rd_en=1, mem_addr=i.
  - LATCH: capture mem_rdata into pi_data.
  - SEND: pi_flag=1 for exactly one cycle.
  - GAP: then, if i<PIXELS-1, increment i and go to READ.
  - GAP length is set so consecutive pi_flag strobes are exactly BYTE_GAP cycles apart.
  - After the last byte (i=PIXELS-1), go straight from SEND to WAIT_RES.
- Latency: start sampled at cycle 0 gives mem_rd_en at cycle 1, pi_flag at cycle 3, and byte k's pi_flag at cycle 3+k*BYTE_GAP.
- pi_data holds its value between strobes; mem_rd_en is 1 only in READ.
- WAIT_RES (final pi_flag at cycle T):
  - po_flag in cycles T+1..T+TIMEOUT_CYCLES inclusive: result<=po_data, go to FINISH.
  - No po_flag by T+TIMEOUT_CYCLES: timed_out<=1 at T+TIMEOUT_CYCLES+1, go to FINISH.
  - po_flag on the last window cycle is accepted; a reply wins over the timeout.
- FINISH: done=1 for one cycle, return to IDLE.
- busy: 1 from cycle 1 through the cycle before done, 0 in the done cycle. start is accepted in the done cycle.
- po_flag outside WAIT_RES is ignored (stale bytes discarded).
- Only the first po_flag in WAIT_RES is captured.
- start while busy=1 is ignored (not queued).
- result and timed_out hold until the next accepted start.
- Counters sized by $clog2 of the largest count; the index never exceeds PIXELS-1 and never wraps.

Test Plan:
- Bench parameters: PIXELS=4, BYTE_GAP=8, TIMEOUT_CYCLES=50.
- Memory[0..3]=0x11,0x22,0x33,0x44; start at cycle 0 -> pi_flag at cycles 3,11,19,27 carrying 0x11,0x22,0x33,0x44; mem_addr 0..3; exactly 4 strobes.
- Same run plus po_flag/po_data=0x07 at cycle 40 -> done at 41, result=0x07, timed_out=0, busy 0 from 41.
- No reply -> timed_out=1 and done at cycle 78 (27+50+1); result=0x00. Reply at exactly cycle 77 -> result captured, timed_out=0.
- po_flag=0x09 at cycle 15 (mid-send), then 0x05 at 35 and 0x06 at 36 -> result=0x05; start pulses at cycles 5 and 20 are ignored; only 4 pi_flag strobes.
- sys_rst asserted at cycle 14 for 2 cycles -> busy, pi_flag, mem_rd_en drop immediately; no further strobes. A new start then restarts the transfer at address 0.
- Back-to-back: start held high continuously -> second transfer starts in the done cycle; first pi_flag of transfer 2 arrives 3 cycles after done.
